// File: rtl/ewb_control.sv
// rtl/ewb_control.sv - control FSM for the single-entry eviction write buffer
module ewb_control #(
    parameter int unsigned DRAIN_IDLE = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic l2_read,
    input  logic l2_write,
    output logic l2_resp,
    input  logic hit,
    output logic read_entry,
    output logic write_entry,
    output logic entry_written,
    output logic pmem_read,
    output logic pmem_write,
    input  logic pmem_resp,
    output logic entry_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM_READ,
        S_FLUSH,
        S_DRAIN
    } state_t;

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(DRAIN_IDLE - 1);

    state_t           state_q, state_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             resp_q, resp_d;
    logic             active_q, active_d;

    logic hit_q;
    logic accept;
    logic resp_c, read_entry_c, write_entry_c, entry_written_c;
    logic pmem_read_c, pmem_write_c;

    // The datapath valid bit never clears, so only a hit on our own valid flag counts.
    assign hit_q  = hit & valid_q;
    // No service in the first cycle after reset, nor right after a response.
    assign accept = active_q & ~resp_q;

    always_comb begin
        state_d         = state_q;
        valid_d         = valid_q;
        idle_cnt_d      = '0;
        active_d        = 1'b1;
        resp_c          = 1'b0;
        read_entry_c    = 1'b0;
        write_entry_c   = 1'b0;
        entry_written_c = 1'b0;
        pmem_read_c     = 1'b0;
        pmem_write_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept && l2_write) begin
                    if (!valid_q || hit_q) begin
                        write_entry_c = 1'b1;
                        resp_c        = 1'b1;
                        valid_d       = 1'b1;
                    end else begin
                        state_d = S_FLUSH;
                    end
                end else if (accept && l2_read) begin
                    if (hit_q) begin
                        read_entry_c = 1'b1;
                        resp_c       = 1'b1;
                    end else begin
                        state_d = S_MEM_READ;
                    end
                end

                if (active_q && valid_q && !l2_read && !l2_write) begin
                    if (idle_cnt_q == IDLE_LAST) begin
                        state_d = S_DRAIN;
                    end else begin
                        idle_cnt_d = idle_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_MEM_READ: begin
                pmem_read_c = 1'b1;
                if (pmem_resp) begin
                    resp_c  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_FLUSH, S_DRAIN: begin
                pmem_write_c    = 1'b1;
                entry_written_c = 1'b1;
                if (pmem_resp) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        resp_d = resp_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            valid_q    <= 1'b0;
            idle_cnt_q <= '0;
            resp_q     <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            idle_cnt_q <= idle_cnt_d;
            resp_q     <= resp_d;
            active_q   <= active_d;
        end
    end

    assign l2_resp       = rst_n & resp_c;
    assign read_entry    = rst_n & read_entry_c;
    assign write_entry   = rst_n & write_entry_c;
    assign entry_written = rst_n & entry_written_c;
    assign pmem_read     = rst_n & pmem_read_c;
    assign pmem_write    = rst_n & pmem_write_c;
    assign entry_valid   = rst_n & valid_q;

    always @(posedge clk) begin
        if (rst_n && active_q && state_q == S_IDLE) begin
            assert (!(l2_read && l2_write))
            else $error("ewb_control: simultaneous l2_read and l2_write");
        end
    end

endmodule
